// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Frame-atomic shadow of the four nibbles, per-digit masking, PWM brightness and blanking guard.
module seven_seg_scan_controller #(
  parameter int unsigned TICKS_PER_DIGIT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        load_req,
  output logic        load_ack,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  brightness,
  output logic [3:0]  anode,
  output logic [3:0]  digit_val,
  output logic        frame_start
);

  localparam int unsigned SUB = TICKS_PER_DIGIT / 16;
  localparam int unsigned TW  = (SUB > 1) ? $clog2(SUB) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    sub_q, sub_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    en_q, en_d;
  logic [3:0]    bright_q, bright_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_start_q, frame_start_d;

  logic tick_wrap;
  logic frame_end;

  assign tick_wrap = (tick_q == TW'(SUB - 1));
  assign frame_end = tick_wrap && (sub_q == 4'hF) && (digit_q == 2'd3);

  always_comb begin
    tick_d        = tick_q + 1'b1;
    sub_d         = sub_q;
    digit_d       = digit_q;
    shadow_d      = shadow_q;
    en_d          = en_q;
    bright_d      = bright_q;
    load_ack_d    = 1'b0;
    frame_start_d = 1'b0;

    if (tick_wrap) begin
      tick_d = '0;
      sub_d  = sub_q + 4'd1;
      if (sub_q == 4'hF) begin
        digit_d = digit_q + 2'd1;
      end
    end

    // Display configuration is only sampled here so a frame is never torn.
    if (frame_end) begin
      en_d          = digit_en;
      bright_d      = brightness;
      frame_start_d = 1'b1;
      if (load_req) begin
        shadow_d   = data_in;
        load_ack_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q        <= '0;
      sub_q         <= '0;
      digit_q       <= '0;
      shadow_q      <= 16'h0000;
      en_q          <= 4'b1111;
      bright_q      <= 4'hF;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      sub_q         <= sub_d;
      digit_q       <= digit_d;
      shadow_q      <= shadow_d;
      en_q          <= en_d;
      bright_q      <= bright_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  logic [3:0] anode_sel;
  logic       lit;

  // Sub-slot 0 is always dark, so digit_val only switches while all anodes are off.
  assign lit = en_q[digit_q] && (sub_q != 4'd0) && (sub_q <= bright_q);

  always_comb begin
    anode_sel = 4'b1110;
    digit_val = shadow_q[3:0];
    case (digit_q)
      2'd0: begin anode_sel = 4'b1110; digit_val = shadow_q[3:0];   end
      2'd1: begin anode_sel = 4'b1101; digit_val = shadow_q[7:4];   end
      2'd2: begin anode_sel = 4'b1011; digit_val = shadow_q[11:8];  end
      2'd3: begin anode_sel = 4'b0111; digit_val = shadow_q[15:12]; end
      default: begin anode_sel = 4'b1111; digit_val = 4'h0; end
    endcase
  end

  assign anode       = lit ? anode_sel : 4'b1111;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench for seven_seg_scan_controller: directed scenarios plus random traffic
// compared against a cycle-number-based model of the display schedule.
module tb_seven_seg_scan_controller;

  localparam int TPD   = 32;
  localparam int SUB   = TPD / 16;
  localparam int FRAME = 4 * TPD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        load_req;
  logic        load_ack;
  logic [3:0]  digit_en;
  logic [3:0]  brightness;
  logic [3:0]  anode;
  logic [3:0]  digit_val;
  logic        frame_start;

  seven_seg_scan_controller #(.TICKS_PER_DIGIT(TPD)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .anode       (anode),
    .digit_val   (digit_val),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: cycle number since reset plus the values latched at the last frame boundary.
  int          n       = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_shadow;
  logic [3:0]  m_en;
  logic [3:0]  m_bright;
  bit          m_cap;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  // Compares the outputs of the current cycle, then drives this cycle's inputs
  // and advances the model and the simulation by one clock.
  task automatic cycle(input logic rst, input logic req, input logic [15:0] din,
                       input logic [3:0] en, input logic [3:0] br);
    int         slot;
    int         sub;
    logic [3:0] exp_an;
    logic [3:0] exp_val;
    bit         fs;
    if (m_valid) begin
      slot    = (n / TPD) % 4;
      sub     = (n % TPD) / SUB;
      exp_an  = (m_en[slot] && sub >= 1 && sub <= int'(m_bright)) ? ~(4'b0001 << slot) : 4'b1111;
      exp_val = 4'((m_shadow >> (4 * slot)) & 16'h000F);
      fs      = (n > 0) && (n % FRAME == 0);
      check("anode",       16'(anode),       16'(exp_an));
      check("digit_val",   16'(digit_val),   16'(exp_val));
      check("load_ack",    16'(load_ack),    16'(fs && m_cap));
      check("frame_start", 16'(frame_start), 16'(fs));
    end
    reset      = rst;
    load_req   = req;
    data_in    = din;
    digit_en   = en;
    brightness = br;
    if (rst) begin
      m_valid  = 1'b1;
      n        = 0;
      m_shadow = 16'h0000;
      m_en     = 4'b1111;
      m_bright = 4'hF;
      m_cap    = 1'b0;
    end else if (m_valid) begin
      if (n % FRAME == FRAME - 1) begin
        m_en     = en;
        m_bright = br;
        m_cap    = req;
        if (req) m_shadow = din;
      end
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0; data_in = '0; digit_en = 4'hF; brightness = 4'hF;

    // Reset with a pending request, then the first load and a full scan.
    repeat (3) cycle(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF);
    repeat (2 * FRAME) cycle(1'b0, 1'b1, 16'h4321, 4'hF, 4'hF);

    // Brightness 4, brightness 0, mask 1010, full brightness.
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'd4);
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'd0);
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'b1010, 4'hF);
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);

    // Atomicity: request raised mid-frame and data changed before the boundary.
    repeat (40) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);
    repeat (60) cycle(1'b0, 1'b1, 16'h1111, 4'hF, 4'hF);
    repeat (28) cycle(1'b0, 1'b1, 16'hABCD, 4'hF, 4'hF);
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);

    // Short request pulse that never meets a boundary.
    repeat (10) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);
    repeat (20) cycle(1'b0, 1'b1, 16'h7777, 4'hF, 4'hF);
    repeat (FRAME) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);

    // Reset mid-operation with a request in flight.
    repeat (FRAME - 30) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'hF);
    repeat (70) cycle(1'b0, 1'b1, 16'h5A5A, 4'hF, 4'hF);
    cycle(1'b1, 1'b1, 16'h5A5A, 4'hF, 4'hF);
    repeat (2 * FRAME) cycle(1'b0, 1'b1, 16'h5A5A, 4'hF, 4'hF);

    // Random traffic: inputs change every cycle, occasional reset.
    for (int i = 0; i < 24 * FRAME; i++) begin
      cycle(($urandom_range(0, 1499) == 0),
            ($urandom_range(0, 3) != 0),
            16'($urandom),
            4'($urandom),
            4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_controller.md
Name: seven_seg_scan_controller

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display. It holds a frame-atomic shadow copy of the four display nibbles {AminusB, AplusB, B, A}. It rotates the active-low anode one-cold and presents the selected nibble on digit_val for the downstream hex segment decoder. It also provides per-digit enable masking, a PWM brightness control, and an inter-digit blanking guard against ghosting.

Parameters:
TICKS_PER_DIGIT, 100000, clk cycles per digit slot (1 ms at 100 MHz). Must be a multiple of 16 and at least 16. SUB = TICKS_PER_DIGIT/16 cycles per PWM sub-slot.

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
data_in  input  16  [3:0]=A, [7:4]=B, [11:8]=AplusB, [15:12]=AminusB
load_req  input  1  level request to load data_in into the shadow register
load_ack  output  1  one-cycle pulse: data_in captured this cycle
digit_en  input  4  per-digit enable; bit i = digit i; 0 blanks that digit
brightness  input  4  PWM duty level, 0 (dark) to 15 (15/16 lit)
anode  output  4  active-low one-cold digit select; 4'b1111 = all off
digit_val  output  4  nibble for the current digit, to the segment decoder
frame_start  output  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Reset (synchronous; takes effect on the clk edge where reset=1):
  - tick_cnt=0, sub_idx=0, digit_idx=0.
  - shadow=16'h0000, en_r=4'b1111, bright_r=4'hF.
  - anode=4'b1111, digit_val=0, load_ack=0, frame_start=0.
  - Any pending load is dropped.
- Counters, all registered:
  - tick_cnt counts 0..SUB-1. On wrap, sub_idx increments over 0..15.
  - When sub_idx wraps, digit_idx increments over 0..3, then wraps to 0.
  - Frame length = 4*TICKS_PER_DIGIT cycles.
  - The first cycle out of reset is cycle 0 of frame 0.
- Digit mapping by digit_idx:
  - 0: anode 4'b1110, nibble A.
  - 1: anode 4'b1101, nibble B.
  - 2: anode 4'b1011, nibble AplusB.
  - 3: anode 4'b0111, nibble AminusB.
- digit_val equals shadow[4*digit_idx+3 : 4*digit_idx] for the whole slot, independent of blanking.
- Lit rule: the anode is driven one-cold iff en_r[digit_idx]=1 AND 1 <= sub_idx <= bright_r. Otherwise anode=4'b1111.
  - Sub-slot 0 is always dark. This is the blanking guard, so digit_val changes only while the anodes are off.
  - bright_r=0 gives fully dark; bright_r=15 gives 15 of 16 sub-slots lit.
- anode, digit_val and frame_start are decoded only from internal registers. There is no combinational path from any input to any output.
- Frame boundary: the cycle where digit_idx wraps 3 to 0. At this boundary:
  - en_r <= digit_en and bright_r <= brightness.
  - If load_req=1: shadow <= data_in, and load_ack=1 in the first cycle of the new frame. The new values are displayed starting in that cycle.
  - frame_start=1 in the same cycle as load_ack.
- Load handshake:
  - The requester holds load_req and keeps data_in stable until it sees load_ack.
  - load_req still high after load_ack causes a reload at the next boundary (level semantics, one ack per frame).
  - load_req asserted and dropped without an intervening boundary: no capture, no ack.
- The shadow, en_r and bright_r never change mid-frame. Changes to data_in, digit_en or brightness mid-frame have no visible effect until the next boundary.
- Reset mid-frame: all state returns to reset values on the next edge. Scanning restarts at digit 0, tick 0. No load_ack is issued for a request in flight.

Test Plan:
All scenarios use TICKS_PER_DIGIT=32 (SUB=2). Cycle numbers count from the first cycle after reset is deasserted.
1. Reset: hold reset 3 cycles with load_req=1 and data_in=16'hFFFF -> during reset and through cycle 1: anode=1111, digit_val=0, load_ack=0. First frame shows zeros with anode=1110 during cycles 2..31.
2. Scan and load: data_in=16'h4321 and load_req=1 from cycle 0 -> load_ack and frame_start high at cycle 128 only. Then:
   - digit_val=1,2,3,4 in cycles 128..159, 160..191, 192..223 and 224..255.
   - anode=1110, 1101, 1011 and 0111 respectively, each dark for the first 2 cycles of its slot.
3. Brightness: brightness=4 applied at a boundary -> in each subsequent 32-cycle slot, the anode is active for exactly slot cycles 2..9 (8 cycles) and 1111 for the other 24. brightness=0 -> anode=1111 for the entire frame.
4. Mask: digit_en=4'b1010 -> digits 1 and 3 lit, digits 0 and 2 anode=1111 for their whole slot. digit_val still steps through all 4 nibbles.
5. Atomicity: load_req=1 with data_in=16'h1111 at cycle 40, changed to 16'hABCD at cycle 100 -> shadow=16'hABCD at cycle 128, ack at 128. digit_val shows 0s from cycles 40 to 127 (no mid-frame change).
6. Reset mid-operation: assert reset for 1 cycle at cycle 70 (digit 2 slot) with load_req=1 -> next cycle anode=1111 and digit_val=0. The scan restarts at digit 0, and no load_ack is issued before the new frame boundary at cycle 71+128.
